bnn_fc_stream_acc: RTL and testbench

BNN_FC_STREAM_ACC -- requirements
Module: bnn_fc_stream_acc

---
 rtl/bnn_fc_stream_acc_if.sv | 29 ++
 rtl/bnn_fc_stream_acc.sv | 94 +++++++++
 tb/tb_bnn_fc_stream_acc.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_fc_stream_acc_if.sv
// Stream bundle for the binary-weight fully-connected accumulator.
// The beat side carries activations, weights and bias in; the result side carries the neuron sum out.
interface bnn_fc_stream_acc_if #(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned LANES = 16,
    parameter int unsigned ACC_W = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES-1:0][IN_W-1:0] in_data;
    logic [LANES-1:0]           in_bw;
    logic                       in_last;
    logic [ACC_W-1:0]           bias;
    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_W-1:0]           out_data;
    logic                       out_bin;
    logic                       err_last;

    modport slave (
        input  in_valid, in_data, in_bw, in_last, bias, out_ready,
        output in_ready, out_valid, out_data, out_bin, err_last
    );

    modport master (
        output in_valid, in_data, in_bw, in_last, bias, out_ready,
        input  in_ready, out_valid, out_data, out_bin, err_last
    );
endinterface

// File: rtl/bnn_fc_stream_acc.sv
// Binary-weight FC neuron: accumulates +/-x over BEATS beats of LANES activations, plus bias,
// and holds one result in an output register that stays open to non-final beats.
module bnn_fc_stream_acc #(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned LANES = 16,
    parameter int unsigned BEATS = 4,
    parameter int unsigned ACC_W = IN_W + $clog2(LANES * BEATS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bnn_fc_stream_acc_if.slave    bus
);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic {
        ST_ACC,
        ST_FULL
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         beat_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  beat_sum;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  total;
    logic                     last_beat;
    logic                     accept;
    logic                     drain;

    // Sign-extend first, then negate, so the most negative input flips without wrapping.
    always_comb begin
        beat_sum = '0;
        term     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            term     = ACC_W'($signed(bus.in_data[i]));
            beat_sum = beat_sum + (bus.in_bw[i] ? term : -term);
        end
    end

    assign last_beat = (beat_cnt == LAST_CNT);
    assign drain     = bus.out_valid && bus.out_ready;

    // Only a final beat needs the output register, so only it can be stalled.
    assign bus.in_ready = !rst_n || !(last_beat && bus.out_valid && !bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign total        = ((beat_cnt == '0) ? $signed(bus.bias) : acc) + beat_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // FULL marks a held result the consumer is refusing.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACC:  if (bus.out_valid && !bus.out_ready) state_next = ST_FULL;
            ST_FULL: if (bus.out_ready)                   state_next = ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt     <= '0;
            acc          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_bin   <= 1'b0;
            bus.err_last  <= 1'b0;
        end else begin
            if (accept) begin
                acc      <= total;
                beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
                if (bus.in_last != last_beat) begin
                    bus.err_last <= 1'b1;
                end
            end
            // A final beat may land in the same cycle the old result drains.
            if (accept && last_beat) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= total;
                bus.out_bin   <= ~total[ACC_W-1];
            end else if (drain) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bnn_fc_stream_acc.sv
// Bench for bnn_fc_stream_acc: directed corner cases plus a randomized stream
// checked against a per-neuron arithmetic reference and a result queue.
module tb_bnn_fc_stream_acc;
    localparam int unsigned IN_W  = 9;
    localparam int unsigned LANES = 16;
    localparam int unsigned BEATS = 4;
    localparam int unsigned ACC_W = 16;

    typedef logic [LANES-1:0][IN_W-1:0] data_t;
    typedef logic [LANES-1:0]           bw_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_fc_stream_acc_if #(.IN_W(IN_W), .LANES(LANES), .ACC_W(ACC_W)) bus ();

    bnn_fc_stream_acc #(.IN_W(IN_W), .LANES(LANES), .BEATS(BEATS), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: beat index, running partial, held result, sticky error, result queue.
    int k = 0;
    int partial = 0;
    int md = 0;
    bit mv = 1'b0;
    bit merr = 1'b0;
    int exp_q[$];

    bit obs_ready, obs_valid, obs_bin, obs_err, obs_hs, rst_ready;
    int obs_data;
    bit exp_ready, exp_valid, exp_err, accepted;
    int exp_data;

    function automatic int lane_sum(input data_t d, input bw_t w);
        int s = 0;
        for (int i = 0; i < int'(LANES); i++) begin
            int x = int'($signed(d[i]));
            s += w[i] ? x : -x;
        end
        return s;
    endfunction

    function automatic data_t fill(input int v);
        data_t d;
        for (int i = 0; i < int'(LANES); i++) d[i] = IN_W'(v);
        return d;
    endfunction

    function automatic data_t rand_data();
        data_t d;
        for (int i = 0; i < int'(LANES); i++) d[i] = IN_W'($urandom);
        return d;
    endfunction

    task automatic tick(input bit v, input data_t d, input bw_t w, input bit l, input int b, input bit ordy);
        bit fin;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_bw     = w;
        bus.in_last   = l;
        bus.bias      = ACC_W'(b);
        bus.out_ready = ordy;
        @(negedge clk);
        obs_ready = bus.in_ready;
        obs_valid = bus.out_valid;
        obs_data  = int'($signed(bus.out_data));
        obs_bin   = bus.out_bin;
        obs_err   = bus.err_last;
        exp_ready = !(k == BEATS - 1 && mv && !ordy);
        exp_valid = mv;
        exp_data  = md;
        exp_err   = merr;
        accepted  = v && exp_ready;
        obs_hs    = obs_valid && ordy;
        fin       = 1'b0;
        if (accepted) begin
            if (l != (k == BEATS - 1)) merr = 1'b1;
            partial = ((k == 0) ? b : partial) + lane_sum(d, w);
            if (k == BEATS - 1) begin
                fin = 1'b1;
                md  = partial;
                exp_q.push_back(partial);
            end
            k = (k + 1) % BEATS;
        end
        if (fin) mv = 1'b1;
        else if (mv && ordy) mv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = rand_data();
        bus.in_bw     = bw_t'($urandom);
        bus.in_last   = 1'b0;
        bus.bias      = ACC_W'($urandom);
        bus.out_ready = 1'b1;
        rst_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b1) rst_ready = 1'b0;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        k = 0; partial = 0; md = 0; mv = 1'b0; merr = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset(3);
        checks++;
        if (rst_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready_during actual=0 required=1");
        end
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b0);
        checks++;
        if (obs_valid !== 1'b0 || obs_data !== 0 || obs_bin !== 1'b0 || obs_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs actual=v%0d d%0d b%0d e%0d required=v0 d0 b0 e0",
                     obs_valid, obs_data, obs_bin, obs_err);
        end
        checks++;
        if (obs_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready_after actual=%0d required=1", obs_ready);
        end
    endtask

    task automatic test_defaults();
        for (int b = 0; b < int'(BEATS); b++) begin
            tick(1'b1, fill(1), '1, b == BEATS - 1, 0, 1'b1);
            checks++;
            if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
                failures++;
                $display("FAIL defaults_beat%0d actual=r%0d v%0d required=r1 v0", b, obs_ready, obs_valid);
            end
        end
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 64 || obs_bin !== 1'b1) begin
            failures++;
            $display("FAIL defaults_result actual=v%0d d%0d b%0d required=v1 d64 b1", obs_valid, obs_data, obs_bin);
        end
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b1);
        checks++;
        if (obs_valid !== 1'b0) begin
            failures++; $display("FAIL defaults_valid_clears actual=%0d required=0", obs_valid);
        end
    endtask

    task automatic test_neg_extreme();
        for (int b = 0; b < int'(BEATS); b++) tick(1'b1, fill(-256), '0, b == BEATS - 1, -1, 1'b1);
        for (int b = 0; b < int'(BEATS); b++) begin
            tick(1'b1, fill(-256), '1, b == BEATS - 1, 0, 1'b1);
            if (b == 0) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_data !== 16383 || obs_bin !== 1'b1) begin
                    failures++;
                    $display("FAIL neg_extreme_pos actual=v%0d d%0d b%0d required=v1 d16383 b1",
                             obs_valid, obs_data, obs_bin);
                end
            end
        end
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== -16384 || obs_bin !== 1'b0) begin
            failures++;
            $display("FAIL neg_extreme_neg actual=v%0d d%0d b%0d required=v1 d-16384 b0", obs_valid, obs_data, obs_bin);
        end
    endtask

    task automatic test_backpressure();
        for (int b = 0; b < int'(BEATS); b++) tick(1'b1, fill(2), '1, b == BEATS - 1, 3, 1'b1);
        for (int b = 0; b < int'(BEATS) - 1; b++) begin
            tick(1'b1, fill(1), '1, 1'b0, -10, 1'b0);
            checks++;
            if (obs_ready !== 1'b1) begin
                failures++; $display("FAIL bp_nonfinal_ready%0d actual=%0d required=1", b, obs_ready);
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, fill(1), '1, 1'b1, -10, 1'b0);
            checks++;
            if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_data !== 131) begin
                failures++;
                $display("FAIL bp_stall%0d actual=r%0d v%0d d%0d required=r0 v1 d131", c, obs_ready, obs_valid, obs_data);
            end
        end
        tick(1'b1, fill(1), '1, 1'b1, -10, 1'b1);
        checks++;
        if (obs_ready !== 1'b1 || obs_data !== 131) begin
            failures++; $display("FAIL bp_release actual=r%0d d%0d required=r1 d131", obs_ready, obs_data);
        end
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b0);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 54) begin
            failures++; $display("FAIL bp_second_result actual=v%0d d%0d required=v1 d54", obs_valid, obs_data);
        end
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b1);
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b1);
        checks++;
        if (obs_valid !== 1'b0) begin
            failures++; $display("FAIL bp_drained actual=%0d required=0", obs_valid);
        end
    endtask

    task automatic test_framing();
        do_reset(1);
        for (int b = 0; b < int'(BEATS); b++) begin
            tick(1'b1, fill(1), '1, b == 1, 0, 1'b1);
            if (b == 2) begin
                checks++;
                if (obs_err !== 1'b1) begin
                    failures++; $display("FAIL framing_err_set actual=%0d required=1", obs_err);
                end
            end
        end
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 64) begin
            failures++; $display("FAIL framing_sum actual=v%0d d%0d required=v1 d64", obs_valid, obs_data);
        end
        for (int b = 0; b < int'(BEATS); b++) tick(1'b1, fill(1), '1, b == BEATS - 1, 1, 1'b1);
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b1);
        checks++;
        if (obs_err !== 1'b1 || obs_data !== 65) begin
            failures++; $display("FAIL framing_sticky actual=e%0d d%0d required=e1 d65", obs_err, obs_data);
        end
        do_reset(1);
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b1);
        checks++;
        if (obs_err !== 1'b0) begin
            failures++; $display("FAIL framing_err_cleared actual=%0d required=0", obs_err);
        end
    endtask

    task automatic test_mid_reset();
        for (int b = 0; b < 2; b++) tick(1'b1, fill(7), '1, 1'b0, 100, 1'b1);
        do_reset(2);
        for (int b = 0; b < int'(BEATS); b++) tick(1'b1, fill(1), '1, b == BEATS - 1, 5, 1'b1);
        tick(1'b0, rand_data(), bw_t'($urandom), 1'b0, 0, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 69) begin
            failures++; $display("FAIL mid_reset_sum actual=v%0d d%0d required=v1 d69", obs_valid, obs_data);
        end
    endtask

    task automatic test_random_gaps();
        int sent = 0;
        int got = 0;
        int b = 0;
        int cyc = 0;
        do_reset(1);
        while (got < 100 && cyc < 20000) begin
            bit v = (sent < 100) && ($urandom_range(0, 3) != 0);
            bit ordy = ($urandom_range(0, 3) != 0);
            int bias_v = int'($urandom_range(0, 32766)) - 16383;
            tick(v, rand_data(), bw_t'($urandom), b == BEATS - 1, bias_v, ordy);
            cyc++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
                checks++; failures++;
                $display("FAIL rand_handshake cyc%0d actual=r%0d v%0d required=r%0d v%0d",
                         cyc, obs_ready, obs_valid, exp_ready, exp_valid);
            end
            if (obs_hs) begin
                int e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h7fffffff;
                checks++;
                if (obs_data !== e || obs_bin !== (e >= 0)) begin
                    failures++;
                    $display("FAIL rand_result n%0d actual=d%0d b%0d required=d%0d b%0d", got, obs_data, obs_bin, e, e >= 0);
                end
                got++;
            end
            if (accepted) begin
                b = (b + 1) % BEATS;
                if (b == 0) sent++;
            end
        end
        checks++;
        if (got != 100 || exp_q.size() != 0) begin
            failures++; $display("FAIL rand_count actual=%0d pending=%0d required=100 pending=0", got, exp_q.size());
        end
        checks++;
        if (obs_err !== 1'b0) begin
            failures++; $display("FAIL rand_no_err actual=%0d required=0", obs_err);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_neg_extreme();
        test_backpressure();
        test_framing();
        test_mid_reset();
        test_random_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
